// File: rtl/seq_multiplier_pkg.sv
// Shared types and limits for the sequential shift-and-add multiplier.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} mult_state_t;

  localparam int MULT_MAX_WIDTH = 16;

endpackage

// File: rtl/seq_multiplier_if.sv
// Start/ready/done handshake bundle between a controller and seq_multiplier.
interface seq_multiplier_if #(
  parameter int WIDTH = 8
) ();

  logic               start;
  logic [WIDTH-1:0]   a;
  logic [WIDTH-1:0]   b;
  logic               ready;
  logic               done;
  logic [2*WIDTH-1:0] product;

  modport master (output start, a, b, input ready, done, product);
  modport slave  (input start, a, b, output ready, done, product);

endinterface

// File: rtl/seq_multiplier_datapath.sv
// Shift-and-add datapath: accumulator, shifting operands and step counter.
// SEQ_MULTIPLIER_EARLY_TERM_EN also ends the run once the multiplier runs out of ones.
module mult_datapath
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic               clock,
  input  logic               reset_L,
  input  logic               load,
  input  logic               step,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               last_step,
  output logic [2*WIDTH-1:0] acc
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [2*WIDTH-1:0] acc_reg;
  logic [2*WIDTH-1:0] acc_next;
  logic [2*WIDTH-1:0] mcand_reg;
  logic [WIDTH-1:0]   mplier_reg;
  logic [WIDTH-1:0]   mplier_next;
  logic [CW-1:0]      count_reg;

  always_comb begin
    acc_next    = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    mplier_next = mplier_reg >> 1;
`ifdef SEQ_MULTIPLIER_EARLY_TERM_EN
    last_step   = (count_reg == CW'(WIDTH)) || (mplier_next == '0);
`else
    // The step that sees count already at WIDTH is the final one; its add is a no-op.
    last_step   = (count_reg == CW'(WIDTH));
`endif
  end

  // Post-step value, so an early exit still includes the add of its own step.
  assign acc = acc_next;

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      acc_reg    <= '0;
      mcand_reg  <= '0;
      mplier_reg <= '0;
      count_reg  <= '0;
    end else if (load) begin
      acc_reg    <= '0;
      mcand_reg  <= {{WIDTH{1'b0}}, a};
      mplier_reg <= b;
      count_reg  <= '0;
    end else if (step) begin
      acc_reg    <= acc_next;
      mcand_reg  <= mcand_reg << 1;
      mplier_reg <= mplier_next;
      count_reg  <= count_reg + CW'(1);
    end
  end

endmodule

// File: rtl/seq_multiplier.sv
// Sequential unsigned multiplier: IDLE/BUSY/DONE control around mult_datapath.
// Optional SEQ_MULTIPLIER_EARLY_TERM_EN shortens BUSY to the multiplier's significant bits.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clock,
  input  logic           reset_L,
  seq_multiplier_if.slave bus
);

  if (WIDTH < 2 || WIDTH > MULT_MAX_WIDTH) begin : g_width_check
    $error("seq_multiplier: WIDTH out of range");
  end

  mult_state_t        state_reg;
  mult_state_t        state_next;
  logic               load;
  logic               step;
  logic               last_step;
  logic [2*WIDTH-1:0] acc;
  logic [2*WIDTH-1:0] product_reg;

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clock     (clock),
    .reset_L   (reset_L),
    .load      (load),
    .step      (step),
    .a         (bus.a),
    .b         (bus.b),
    .last_step (last_step),
    .acc       (acc)
  );

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    load       = 1'b0;
    step       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          load       = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        step = 1'b1;
        if (last_step) begin
          state_next = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      product_reg <= '0;
    end else if (state_reg == BUSY && last_step) begin
      product_reg <= acc;
    end
  end

  assign bus.ready   = (state_reg == IDLE);
  assign bus.done    = (state_reg == DONE);
  assign bus.product = product_reg;

endmodule
